reflet_uart_tx_arbiter: RTL
===========================

# reflet_uart_tx_arbiter

Shares the single transmit channel of the reflet UART between several on-chip requesters (CPU shim, debug monitor, DMA-style producers). Each requester offers bytes with a valid/ready handshake. The arbiter picks one requester per byte by round-robin, optionally lets the winner keep the channel for a bounded burst, and drives the UART core's `data_tx`/`start_transmit`/`end_transmit` handshake. A watchdog aborts transfers whose completion never arrives.

## Interface
- `nreq`, 4: number of requesters (2..8).
- `timeout`, 2048: clock cycles allowed in SEND before abort (1..65535); 16-bit counter.
- `max_burst`, 16: maximum consecutive bytes one locked requester may send (1..255); 8-bit counter.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  when low, no new grant is issued; an in-flight byte completes.
- `req_valid`  in  nreq  requester i has a byte on `req_data[8i+7:8i]`; held until its `req_ready` pulse.
- `req_data`  in  8*nreq  packed request bytes.
- `req_lock`  in  nreq  requester i asks to keep the channel after the current byte.
- `req_ready`  out  nreq  one-cycle pulse: the byte sampled on the previous edge was accepted.
- `grant`  out  nreq  one-hot current owner; 0 when IDLE.
- `tx_data`  out  8  byte to the UART core `data_tx`.
- `tx_start`  out  1  level to the UART core `start_transmit`.
- `tx_end`  in  1  UART core `end_transmit` (level, high during the stop-bit period).
- `timeout_err`  out  1  one-cycle pulse on watchdog abort.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SEND, RELEASE.
- IDLE, when `enable=1` and any `req_valid`: select a winner w.
  - If `lock_active=1` and `req_valid[owner]=1`, w = owner.
  - Otherwise clear `lock_active`, then w = first valid index scanning upward from `rr_ptr+1` modulo nreq.
  - On that edge: `tx_data`←byte w; `grant`←onehot(w); `rr_ptr`←w; `req_ready[w]`←1; `tx_start`←1; watchdog←0; go to SEND.
  - If `req_lock[w]=1` and `burst_cnt+1 < max_burst`: `lock_active`←1 and `burst_cnt`←`burst_cnt`+1. Otherwise `lock_active`←0 and `burst_cnt`←0.
- SEND: `tx_start` held high. `tx_end_q` registers `tx_end`.
  - Rising edge (`tx_end=1` and `tx_end_q=0`): `tx_start`←0, go to RELEASE.
  - A `tx_end` already high on entry is not an edge.
  - Watchdog increments each SEND cycle. At value `timeout-1` with no edge: `tx_start`←0, `timeout_err` pulses, `lock_active`←0, `burst_cnt`←0, `grant`←0, go to IDLE.
- RELEASE: wait for `tx_end=0`, then `grant`←0 and go to IDLE. This stops the core from restarting on the same byte.
- `enable` low in SEND/RELEASE has no effect. In IDLE it blocks selection but preserves `lock_active`.
- Reset in any state: next edge forces IDLE. All outputs go to their reset values and the in-flight byte is dropped.
- Reset values: `tx_start`=0, `tx_data`=0, `grant`=0, `req_ready`=0, `timeout_err`=0, `busy`=0, `rr_ptr`=nreq-1 (requester 0 wins first), `lock_active`=0, `burst_cnt`=0, `tx_end_q`=0.

## Timing
- Request sampled at edge N → `req_ready[w]`, `grant`, `tx_start` and `tx_data` all valid from edge N+1.
- `req_ready` is high for exactly one cycle. The requester updates `req_valid`/data on edge N+2.
- SEND lasts at least 2 cycles, so IDLE is never re-entered before the requester has seen ready. No double acceptance.
- `tx_end` rising edge seen at edge M → `tx_start`=0 from edge M+1.
- First IDLE cycle is the edge after `tx_end` is sampled low in RELEASE. The next grant follows on the following edge.
- Timeout: `timeout_err` is high on edge K+timeout, where K is the SEND entry edge.
- Simultaneous valids: exactly one winner per grant; no requester waits more than nreq-1 grants unless locked.

## Test plan
- Reset, then `req_valid`=4'b0101 with bytes 0x41/0x43, behavioural core stub → 0x41 (req0) sent first, then 0x43 (req2). Each `req_ready` pulse is exactly one cycle and `grant` is one-hot.
- All four valid continuously → grant order 0,1,2,3,0; `tx_data` matches each requester's byte.
- req1 with `req_lock`=1 and `max_burst`=3, req2 also valid → req1, req1, req1, req2. After the third byte the lock is forced off.
- Stub never asserts `tx_end`, `timeout`=100 → `timeout_err` pulses once on edge 100 after SEND entry, `tx_start`=0, `grant`=0, IDLE.
- `tx_end` stuck high when entering SEND → no early completion. The watchdog fires unless a real low→high edge occurs.
- Reset asserted mid-SEND → next edge has `tx_start`=0, `busy`=0, `grant`=0. After release, req0 has priority again.

Source files
------------

// File: rtl/reflet_uart_tx_arbiter.sv
// reflet_uart_tx_arbiter: round-robin sharing of the UART transmit channel with burst lock and watchdog
module reflet_uart_tx_arbiter #(
  parameter int nreq = 4,
  parameter int timeout = 2048,
  parameter int max_burst = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [nreq-1:0]      req_valid,
  input  logic [8*nreq-1:0]    req_data,
  input  logic [nreq-1:0]      req_lock,
  output logic [nreq-1:0]      req_ready,
  output logic [nreq-1:0]      grant,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_end,
  output logic                 timeout_err,
  output logic                 busy
);
  localparam int PW = $clog2(nreq);
  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;
  state_t          r_state;
  logic [PW-1:0]   r_rr_ptr, w_win, w_idx;
  logic [nreq-1:0] w_onehot;
  logic            r_lock_active, w_keep, w_lock_next, r_tx_end_q;
  logic [7:0]      r_burst_cnt, w_burst_base;
  logic [15:0]     r_wd;
  assign busy = r_state != IDLE;
  // winner: locked owner if still valid, else first valid index after the last winner
  always_comb begin
    w_keep = r_lock_active && req_valid[r_rr_ptr];
    w_win = r_rr_ptr;
    w_idx = '0;
    for (int k = nreq; k >= 1; k--) begin
      w_idx = PW'((int'(r_rr_ptr) + k) % nreq);
      if (!w_keep && req_valid[w_idx]) w_win = w_idx;
    end
    w_onehot = '0;
    w_onehot[w_win] = 1'b1;
    w_burst_base = w_keep ? r_burst_cnt : 8'd0;
    w_lock_next = req_lock[w_win] && (int'(w_burst_base) + 1 < max_burst);
  end
  // grant / send / release sequencing with watchdog abort
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      tx_start <= 1'b0;
      tx_data <= 8'd0;
      grant <= '0;
      req_ready <= '0;
      timeout_err <= 1'b0;
      r_rr_ptr <= PW'(nreq - 1);
      r_lock_active <= 1'b0;
      r_burst_cnt <= 8'd0;
      r_tx_end_q <= 1'b0;
      r_wd <= 16'd0;
    end else begin
      req_ready <= '0;
      timeout_err <= 1'b0;
      r_tx_end_q <= tx_end;
      case (r_state)
        IDLE: if (enable && |req_valid) begin
          tx_data <= req_data[{w_win, 3'b000} +: 8];
          grant <= w_onehot;
          req_ready <= w_onehot;
          tx_start <= 1'b1;
          r_rr_ptr <= w_win;
          r_wd <= 16'd0;
          r_lock_active <= w_lock_next;
          r_burst_cnt <= w_lock_next ? w_burst_base + 8'd1 : 8'd0;
          r_state <= SEND;
        end
        SEND: if (tx_end && !r_tx_end_q) begin
          tx_start <= 1'b0;
          r_state <= RELEASE;
        end else if (r_wd == 16'(timeout - 1)) begin
          tx_start <= 1'b0;
          timeout_err <= 1'b1;
          r_lock_active <= 1'b0;
          r_burst_cnt <= 8'd0;
          grant <= '0;
          r_state <= IDLE;
        end else r_wd <= r_wd + 16'd1;
        RELEASE: if (!tx_end) begin
          grant <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
